// File: rtl/prio_queue.sv
// prio_queue: register-based binary-heap priority queue with valid/ready on both sides.
// Define PRIO_QUEUE_HWM_EN to add the hwm/hwm_clear high-water-mark ports.
module prio_queue #(
  parameter int DATA_WIDTH = 10,
  parameter int PRIO_WIDTH = 32,
  parameter int TOT_SIZE   = 7,
  parameter int MIN_MODE   = 0
) (
  input  logic                          sink_clk,
  input  logic                          reset,
  input  logic                          sink_valid,
  output logic                          sink_ready,
  input  logic [DATA_WIDTH-1:0]         sink_data,
  input  logic [PRIO_WIDTH-1:0]         sink_prio,
  output logic                          source_valid,
  input  logic                          source_ready,
  output logic [DATA_WIDTH-1:0]         source_data,
  output logic [PRIO_WIDTH-1:0]         source_prio,
  output logic [$clog2(TOT_SIZE+1)-1:0] count,
  output logic                          empty,
`ifdef PRIO_QUEUE_HWM_EN
  input  logic                          hwm_clear,
  output logic [$clog2(TOT_SIZE+1)-1:0] hwm,
`endif
  output logic                          full
);

  localparam int CW = $clog2(TOT_SIZE + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(TOT_SIZE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SIFT_UP   = 2'd1,
    SIFT_DOWN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [PRIO_WIDTH-1:0] prio_q [TOT_SIZE];
  logic [PRIO_WIDTH-1:0] prio_d [TOT_SIZE];
  logic [DATA_WIDTH-1:0] data_q [TOT_SIZE];
  logic [DATA_WIDTH-1:0] data_d [TOT_SIZE];
  logic                  sink_ready_q, source_valid_q, empty_q, full_q;
  logic [DATA_WIDTH-1:0] src_data_q;
  logic [PRIO_WIDTH-1:0] src_prio_q;

  logic                  push_s, pop_s;
  logic [CW-1:0]         par_s;
  logic [CW:0]           lc_s, rc_s, ch_s;
  logic [CW-1:0]         ch_idx_s;

  // Ordering is strict so equal priorities never swap.
  function automatic logic better(input logic [PRIO_WIDTH-1:0] a, input logic [PRIO_WIDTH-1:0] b);
    logic res;
    if (MIN_MODE != 0) begin
      res = ($signed(a) < $signed(b));
    end else begin
      res = ($signed(a) > $signed(b));
    end
    return res;
  endfunction

  // Next-state logic for FSM, occupancy, sift index and heap contents.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    prio_d   = prio_q;
    data_d   = data_q;
    push_s   = sink_valid & sink_ready_q;
    pop_s    = source_valid_q & source_ready;
    par_s    = (idx_q - CW'(1)) >> 1;
    lc_s     = {idx_q, 1'b1};
    rc_s     = lc_s + (CW+1)'(1);
    ch_s     = lc_s;
    ch_idx_s = lc_s[CW-1:0];
    case (state_q)
      IDLE: begin
        if (push_s && pop_s) begin
          prio_d[0] = sink_prio;
          data_d[0] = sink_data;
          idx_d     = '0;
          state_d   = (count_q > CW'(1)) ? SIFT_DOWN : IDLE;
        end else if (push_s) begin
          prio_d[count_q] = sink_prio;
          data_d[count_q] = sink_data;
          count_d         = count_q + CW'(1);
          idx_d           = count_q;
          state_d         = (count_q == '0) ? IDLE : SIFT_UP;
        end else if (pop_s) begin
          prio_d[0] = prio_q[count_q - CW'(1)];
          data_d[0] = data_q[count_q - CW'(1)];
          count_d   = count_q - CW'(1);
          idx_d     = '0;
          state_d   = (count_q > CW'(2)) ? SIFT_DOWN : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      SIFT_UP: begin
        if ((idx_q != '0) && better(prio_q[idx_q], prio_q[par_s])) begin
          prio_d[idx_q] = prio_q[par_s];
          data_d[idx_q] = data_q[par_s];
          prio_d[par_s] = prio_q[idx_q];
          data_d[par_s] = data_q[idx_q];
          idx_d         = par_s;
          // Reaching the root needs no further compare, saving a cycle.
          state_d       = (par_s == '0) ? IDLE : SIFT_UP;
        end else begin
          state_d = IDLE;
        end
      end
      SIFT_DOWN: begin
        if ((rc_s < {1'b0, count_q}) && better(prio_q[rc_s[CW-1:0]], prio_q[lc_s[CW-1:0]])) begin
          ch_s = rc_s;
        end else begin
          ch_s = lc_s;
        end
        ch_idx_s = ch_s[CW-1:0];
        if ((lc_s < {1'b0, count_q}) && better(prio_q[ch_idx_s], prio_q[idx_q])) begin
          prio_d[idx_q]    = prio_q[ch_idx_s];
          data_d[idx_q]    = data_q[ch_idx_s];
          prio_d[ch_idx_s] = prio_q[idx_q];
          data_d[ch_idx_s] = data_q[idx_q];
          idx_d            = ch_idx_s;
          // Stop early when the new position is already a leaf.
          state_d          = ({ch_s, 1'b1} < {2'b00, count_q}) ? SIFT_DOWN : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and outputs, registered from next-state so they align with the heap.
  always_ff @(posedge sink_clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      idx_q          <= '0;
      sink_ready_q   <= 1'b0;
      source_valid_q <= 1'b0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      src_data_q     <= '0;
      src_prio_q     <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      sink_ready_q   <= (state_d == IDLE) && (count_d != FULL_CNT);
      source_valid_q <= (state_d == IDLE) && (count_d != '0);
      empty_q        <= (count_d == '0);
      full_q         <= (count_d == FULL_CNT);
      src_data_q     <= (count_d != '0) ? data_d[0] : '0;
      src_prio_q     <= (count_d != '0) ? prio_d[0] : '0;
    end
  end

  // Heap storage; contents are meaningless until written, so no reset.
  always_ff @(posedge sink_clk) begin
    prio_q <= prio_d;
    data_q <= data_d;
  end

`ifdef PRIO_QUEUE_HWM_EN
  logic [CW-1:0] hwm_q;

  // High-water mark of occupancy, reloadable with the current count.
  always_ff @(posedge sink_clk or negedge reset) begin
    if (!reset) begin
      hwm_q <= '0;
    end else if (hwm_clear) begin
      hwm_q <= count_q;
    end else if (count_d > hwm_q) begin
      hwm_q <= count_d;
    end else begin
      hwm_q <= hwm_q;
    end
  end

  assign hwm = hwm_q;
`endif

  assign sink_ready   = sink_ready_q;
  assign source_valid = source_valid_q;
  assign source_data  = src_data_q;
  assign source_prio  = src_prio_q;
  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;

endmodule

// File: tb/tb_prio_queue.sv
// Bench for prio_queue: unit 0 is a max-heap, unit 1 a min-heap; table vectors plus corner sequences.
module tb_prio_queue;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sv [2];
  logic              sk_r [2];
  logic [9:0]        sd [2];
  logic signed [31:0] sp [2];
  logic              so_v [2];
  logic              so_r [2];
  logic [9:0]        od [2];
  logic signed [31:0] op [2];
  logic [2:0]        cnt [2];
  logic              emp [2];
  logic              ful [2];
`ifdef PRIO_QUEUE_HWM_EN
  logic              hclr [2];
  logic [2:0]        hwmv [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_queue #(.DATA_WIDTH(10), .PRIO_WIDTH(32), .TOT_SIZE(7), .MIN_MODE(0)) u_max (
    .sink_clk(clk), .reset(rst_n),
    .sink_valid(sv[0]), .sink_ready(sk_r[0]), .sink_data(sd[0]), .sink_prio(sp[0]),
    .source_valid(so_v[0]), .source_ready(so_r[0]), .source_data(od[0]), .source_prio(op[0]),
    .count(cnt[0]), .empty(emp[0]),
`ifdef PRIO_QUEUE_HWM_EN
    .hwm_clear(hclr[0]), .hwm(hwmv[0]),
`endif
    .full(ful[0])
  );

  prio_queue #(.DATA_WIDTH(10), .PRIO_WIDTH(32), .TOT_SIZE(7), .MIN_MODE(1)) u_min (
    .sink_clk(clk), .reset(rst_n),
    .sink_valid(sv[1]), .sink_ready(sk_r[1]), .sink_data(sd[1]), .sink_prio(sp[1]),
    .source_valid(so_v[1]), .source_ready(so_r[1]), .source_data(od[1]), .source_prio(op[1]),
    .count(cnt[1]), .empty(emp[1]),
`ifdef PRIO_QUEUE_HWM_EN
    .hwm_clear(hclr[1]), .hwm(hwmv[1]),
`endif
    .full(ful[1])
  );

  typedef struct {
    int         u;
    bit         is_pop;
    logic [9:0] d;
    int         p;
    bit         chk_d;
    int         exp_d;
    int         exp_p;
    int         exp_cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int u);
    int n = 0;
    while (!(sk_r[u] || so_v[u]) && n < 20) begin
      tick();
      n++;
    end
    check("idle_wait", longint'(sk_r[u] | so_v[u]), 1);
  endtask

  task automatic push(input int u, input logic [9:0] d, input int p);
    int n = 0;
    while (!sk_r[u] && n < 20) begin
      tick();
      n++;
    end
    if (!sk_r[u]) check("push_ready_wait", longint'(sk_r[u]), 1);
    sv[u] = 1'b1;
    sd[u] = d;
    sp[u] = p;
    tick();
    sv[u] = 1'b0;
    wait_idle(u);
  endtask

  task automatic pop(input int u, output logic [9:0] d, output int p);
    int n = 0;
    while (!so_v[u] && n < 20) begin
      tick();
      n++;
    end
    if (!so_v[u]) check("pop_valid_wait", longint'(so_v[u]), 1);
    d = od[u];
    p = op[u];
    so_r[u] = 1'b1;
    tick();
    so_r[u] = 1'b0;
    wait_idle(u);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] gd;
    int         gp;
    int         lowcyc;
    int         t2e [7];

    for (int u = 0; u < 2; u++) begin
      sv[u] = 1'b0; sd[u] = '0; sp[u] = '0; so_r[u] = 1'b0;
`ifdef PRIO_QUEUE_HWM_EN
      hclr[u] = 1'b0;
`endif
    end

    // max-heap: spec test 1
    tbl[0]  = '{0, 1'b0, 10'd1, 90, 1'b1, 1, 90, 1};
    tbl[1]  = '{0, 1'b0, 10'd2, 30, 1'b1, 1, 90, 2};
    tbl[2]  = '{0, 1'b0, 10'd3, 70, 1'b1, 1, 90, 3};
    tbl[3]  = '{0, 1'b0, 10'd4, 50, 1'b1, 1, 90, 4};
    tbl[4]  = '{0, 1'b1, 10'd0, 0,  1'b1, 1, 90, 3};
    tbl[5]  = '{0, 1'b1, 10'd0, 0,  1'b1, 3, 70, 2};
    tbl[6]  = '{0, 1'b1, 10'd0, 0,  1'b1, 4, 50, 1};
    tbl[7]  = '{0, 1'b1, 10'd0, 0,  1'b1, 2, 30, 0};
    // min-heap with signed priorities: spec test 4
    tbl[8]  = '{1, 1'b0, 10'd1, -5,  1'b1, 1, -5,  1};
    tbl[9]  = '{1, 1'b0, 10'd2, 3,   1'b1, 1, -5,  2};
    tbl[10] = '{1, 1'b0, 10'd3, -20, 1'b1, 3, -20, 3};
    tbl[11] = '{1, 1'b0, 10'd4, 3,   1'b1, 3, -20, 4};
    tbl[12] = '{1, 1'b1, 10'd0, 0,   1'b1, 3, -20, 3};
    tbl[13] = '{1, 1'b1, 10'd0, 0,   1'b1, 1, -5,  2};
    tbl[14] = '{1, 1'b1, 10'd0, 0,   1'b0, 0, 3,   1};
    tbl[15] = '{1, 1'b1, 10'd0, 0,   1'b0, 0, 3,   0};

    // reset state
    tick(); tick();
    check("rst sink_ready", longint'(sk_r[0]), 0);
    check("rst source_valid", longint'(so_v[0]), 0);
    check("rst count", longint'(cnt[0]), 0);
    check("rst empty", longint'(emp[0]), 1);
    check("rst full", longint'(ful[0]), 0);
    check("rst source_prio", longint'(op[0]), 0);
    check("rst source_data", longint'(od[0]), 0);
    rst_n = 1'b1;
    tick();
    check("post-rst sink_ready", longint'(sk_r[0]), 1);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].is_pop) begin
        pop(tbl[i].u, gd, gp);
        if (tbl[i].chk_d) check($sformatf("vec%0d pop data", i), longint'(gd), tbl[i].exp_d);
        check($sformatf("vec%0d pop prio", i), gp, tbl[i].exp_p);
      end else begin
        push(tbl[i].u, tbl[i].d, tbl[i].p);
        check($sformatf("vec%0d root data", i), longint'(od[tbl[i].u]), tbl[i].exp_d);
        check($sformatf("vec%0d root prio", i), longint'(op[tbl[i].u]), tbl[i].exp_p);
      end
      check($sformatf("vec%0d count", i), longint'(cnt[tbl[i].u]), tbl[i].exp_cnt);
    end
    check("t1 empty", longint'(emp[0]), 1);
    check("t1 empty prio", longint'(op[0]), 0);

    // test 2: fill, hold an extra push, pop to make room
    for (int i = 0; i < 7; i++) push(0, 10'(i + 1), (i + 1) * 10);
    check("t2 full", longint'(ful[0]), 1);
    check("t2 sink_ready", longint'(sk_r[0]), 0);
    check("t2 count", longint'(cnt[0]), 7);
    sv[0] = 1'b1; sd[0] = 10'd8; sp[0] = 5;
    tick(); tick();
    check("t2 held count", longint'(cnt[0]), 7);
    gp = op[0];
    so_r[0] = 1'b1;
    tick();
    so_r[0] = 1'b0;
    check("t2 first pop", gp, 70);
    check("t2 count after pop", longint'(cnt[0]), 6);
    lowcyc = 0;
    while (!sk_r[0] && lowcyc < 10) begin
      tick();
      lowcyc++;
    end
    check("t2 sift cycles", lowcyc, 2);
    tick();
    sv[0] = 1'b0;
    check("t2 refill count", longint'(cnt[0]), 7);
    check("t2 refill full", longint'(ful[0]), 1);
    wait_idle(0);
    check("t2 root", longint'(op[0]), 60);
    t2e = '{60, 50, 40, 30, 20, 10, 5};
    for (int i = 0; i < 7; i++) begin
      pop(0, gd, gp);
      check($sformatf("t2 drain%0d", i), gp, t2e[i]);
    end
    check("t2 drained", longint'(emp[0]), 1);

    // test 3: simultaneous push and pop
    push(0, 10'd1, 90);
    push(0, 10'd2, 70);
    sv[0] = 1'b1; sd[0] = 10'd3; sp[0] = 95;
    so_r[0] = 1'b1;
    gd = od[0];
    gp = op[0];
    tick();
    sv[0] = 1'b0; so_r[0] = 1'b0;
    check("t3 got prio", gp, 90);
    check("t3 got data", longint'(gd), 1);
    check("t3 count", longint'(cnt[0]), 2);
    wait_idle(0);
    check("t3 root prio", longint'(op[0]), 95);
    check("t3 root data", longint'(od[0]), 3);
    pop(0, gd, gp);
    pop(0, gd, gp);
    check("t3 last", gp, 70);

    // test 5: reset mid SIFT_UP
    push(0, 10'd1, 10);
    push(0, 10'd2, 20);
    push(0, 10'd3, 30);
    sv[0] = 1'b1; sd[0] = 10'd4; sp[0] = 40;
    tick();
    sv[0] = 1'b0;
    check("t5 mid sift", longint'(sk_r[0] | so_v[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5 rst count", longint'(cnt[0]), 0);
    check("t5 rst empty", longint'(emp[0]), 1);
    check("t5 rst source_valid", longint'(so_v[0]), 0);
    check("t5 rst sink_ready", longint'(sk_r[0]), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5 ready after release", longint'(sk_r[0]), 1);
    sv[0] = 1'b1; sd[0] = 10'd9; sp[0] = 40;
    tick();
    sv[0] = 1'b0;
    check("t5 source_valid", longint'(so_v[0]), 1);
    check("t5 source_prio", longint'(op[0]), 40);
    pop(0, gd, gp);

`ifdef PRIO_QUEUE_HWM_EN
    for (int i = 0; i < 5; i++) push(0, 10'(i), i + 1);
    for (int i = 0; i < 3; i++) pop(0, gd, gp);
    check("t6 hwm", longint'(hwmv[0]), 5);
    check("t6 count", longint'(cnt[0]), 2);
    hclr[0] = 1'b1;
    tick();
    hclr[0] = 1'b0;
    check("t6 hwm cleared", longint'(hwmv[0]), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
